// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared types and helpers for the synth voice pool.
//   alloc_state_t : voice_allocator FSM states
//   commit_t      : outcome of an allocator scan, held through COMMIT
//   key_t         : MIDI key number
//   AGE_MAX       : saturation value of the default-width age counter
//   clogb2        : index width for a pool of the given size (minimum 1)
// -----------------------------------------------------------------------------
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } alloc_state_t;

   typedef enum logic [2:0] {
      CM_NONE    = 3'd0,
      CM_ON      = 3'd1,   // note-on into a retriggered, free or releasing slot
      CM_STEAL   = 3'd2,   // note-on that took a held voice
      CM_DROP    = 3'd3,   // note-on with every slot held and stealing disabled
      CM_OFF     = 3'd4,   // note-off that matched a held key
      CM_OFF_ERR = 3'd5    // note-off that matched nothing
   } commit_t;

   typedef logic [6:0] key_t;

   localparam int AGE_W_DEFAULT = 8;
   localparam int AGE_MAX       = (1 << AGE_W_DEFAULT) - 1;

   function automatic int clogb2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/voice_age_table.sv
// -----------------------------------------------------------------------------
// voice_age_table
// Per-slot key and age storage for voice_allocator.
// On a write, the addressed slot takes the new key and its age restarts at 0;
// every other slot flagged in held_i ages by one, saturating at all-ones.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   wr_en_i       : commit a note-on this cycle
//   wr_idx_i      : slot receiving the note
//   wr_key_i      : key written into that slot
//   held_i        : slots holding a pressed key before this write
//   slot_key_o    : stored key per slot
//   slot_age_o    : age per slot (note-ons seen since the slot was assigned)
// -----------------------------------------------------------------------------
module voice_age_table
   import synth_pkg::*;
#(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = 3,
   parameter int AGE_W   = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_en_i,
   input  logic [V_WIDTH-1:0]           wr_idx_i,
   input  key_t                         wr_key_i,
   input  logic [VOICES-1:0]            held_i,
   output key_t [VOICES-1:0]            slot_key_o,
   output logic [VOICES-1:0][AGE_W-1:0] slot_age_o
);

   key_t [VOICES-1:0]            key_q;
   logic [VOICES-1:0][AGE_W-1:0] age_q;

   // NOTE: this small table is cleared by reset so that the age comparisons
   // after reset are deterministic; a large RAM would not be reset this way.
   // NOTE: sequential state uses non-blocking assignments so every slot
   // updates from the same pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         key_q <= '0;
         age_q <= '0;
      end else if (wr_en_i) begin
         for (int i = 0; i < VOICES; i++) begin
            if (V_WIDTH'(i) == wr_idx_i) begin
               key_q[i] <= wr_key_i;
               age_q[i] <= '0;
            end else if (held_i[i] && !(&age_q[i])) begin
               age_q[i] <= age_q[i] + AGE_W'(1);
            end
         end
      end
   end

   assign slot_key_o = key_q;
   assign slot_age_o = age_q;

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Assigns MIDI note-on events to synth voice slots and releases them on
// note-off. Each accepted event is scanned over all slots one per cycle
// (exactly VOICES cycles), then committed; the strobes, cur_* bus and keys_on
// all reflect the new allocation during the single COMMIT cycle.
// Note-on slot priority: same held key, lowest free idle slot, oldest slot in
// release, oldest held slot (steal).
// Build option: define VOICE_ALLOC_STEAL_EN to enable stealing. Without it a
// note-on finding every slot held is dropped and signalled on steal.
// Ports:
//   CLOCK_25, iRST               : clock, asynchronous active-high reset
//   ev_valid/ev_ready            : note event handshake
//   ev_on, ev_key, ev_vel        : event type, key, velocity
//   voice_free                   : envelope idle per slot
//   note_on, note_off            : one-cycle strobes for slot cur_key_adr
//   keys_on, active_keys         : held slots and their count
//   cur_key_adr/val, cur_vel_*   : data for the latest strobe, held
//   off_note_error               : note-off matched no held key
//   steal                        : held voice taken (or note dropped)
// -----------------------------------------------------------------------------
module voice_allocator
   import synth_pkg::*;
#(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = clogb2(VOICES),
   parameter int AGE_W   = AGE_W_DEFAULT
) (
   input  logic               CLOCK_25,
   input  logic               iRST,
   input  logic               ev_valid,
   output logic               ev_ready,
   input  logic               ev_on,
   input  logic [6:0]         ev_key,
   input  logic [6:0]         ev_vel,
   input  logic [VOICES-1:0]  voice_free,
   output logic               note_on,
   output logic               note_off,
   output logic [VOICES-1:0]  keys_on,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [7:0]         cur_vel_off,
   output logic [V_WIDTH:0]   active_keys,
   output logic               off_note_error,
   output logic               steal
);

   alloc_state_t state_q, state_d;
   logic [V_WIDTH-1:0] idx_q;
   logic               ev_on_q;
   key_t               ev_key_q;
   logic [6:0]         ev_vel_q;

   // Running candidates built up over the scan
   logic               hit_found_q,  hit_found_d;
   logic [V_WIDTH-1:0] hit_idx_q,    hit_idx_d;
   logic               free_found_q, free_found_d;
   logic [V_WIDTH-1:0] free_idx_q,   free_idx_d;
   logic               rel_found_q,  rel_found_d;
   logic [V_WIDTH-1:0] rel_idx_q,    rel_idx_d;
   logic [AGE_W-1:0]   rel_age_q,    rel_age_d;
`ifdef VOICE_ALLOC_STEAL_EN
   logic               old_found_q,  old_found_d;
   logic [V_WIDTH-1:0] old_idx_q,    old_idx_d;
   logic [AGE_W-1:0]   old_age_q,    old_age_d;
`endif

   commit_t            kind_q, cm_kind_d;
   logic [V_WIDTH-1:0] cm_idx_d;
   logic [VOICES-1:0]  keys_on_q;
   logic [V_WIDTH-1:0] cur_adr_q;
   key_t               cur_key_q;
   logic [6:0]         cur_von_q, cur_voff_q;

   key_t [VOICES-1:0]            slot_key;
   logic [VOICES-1:0][AGE_W-1:0] slot_age;

   logic accept, scan_last, tbl_wr;

   assign accept    = ev_valid && ev_ready;
   assign scan_last = (state_q == SCAN) && (idx_q == V_WIDTH'(VOICES - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLOCK_25 or posedge iRST) begin
      if (iRST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // NOTE: every combinational output gets a default first so no latch is
   // inferred on paths that do not assign it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (scan_last) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ev_ready       = 1'b0;
      note_on        = 1'b0;
      note_off       = 1'b0;
      off_note_error = 1'b0;
      steal          = 1'b0;
      case (state_q)
         IDLE:    ev_ready = !iRST;   // nothing is offered as ready while in reset
         COMMIT: begin
            note_on        = (kind_q == CM_ON) || (kind_q == CM_STEAL);
            note_off       = (kind_q == CM_OFF);
            off_note_error = (kind_q == CM_OFF_ERR);
            steal          = (kind_q == CM_STEAL) || (kind_q == CM_DROP);
         end
         default: ;
      endcase
   end

   // ---------------- scan comparators ----------------
   // The _d values include the slot examined this cycle, so on the last scan
   // cycle they hold the final candidates for the commit decision.
   always_comb begin
      hit_found_d  = hit_found_q;
      hit_idx_d    = hit_idx_q;
      free_found_d = free_found_q;
      free_idx_d   = free_idx_q;
      rel_found_d  = rel_found_q;
      rel_idx_d    = rel_idx_q;
      rel_age_d    = rel_age_q;
`ifdef VOICE_ALLOC_STEAL_EN
      old_found_d  = old_found_q;
      old_idx_d    = old_idx_q;
      old_age_d    = old_age_q;
`endif
      if (state_q == SCAN) begin
         if (keys_on_q[idx_q]) begin
            if (!hit_found_q && slot_key[idx_q] == ev_key_q) begin
               hit_found_d = 1'b1;
               hit_idx_d   = idx_q;
            end
`ifdef VOICE_ALLOC_STEAL_EN
            // strictly greater keeps ties on the lowest index
            if (!old_found_q || slot_age[idx_q] > old_age_q) begin
               old_found_d = 1'b1;
               old_idx_d   = idx_q;
               old_age_d   = slot_age[idx_q];
            end
`endif
         end else if (voice_free[idx_q]) begin
            if (!free_found_q) begin
               free_found_d = 1'b1;
               free_idx_d   = idx_q;
            end
         end else if (!rel_found_q || slot_age[idx_q] > rel_age_q) begin
            rel_found_d = 1'b1;
            rel_idx_d   = idx_q;
            rel_age_d   = slot_age[idx_q];
         end
      end
   end

   // ---------------- commit decision ----------------
   always_comb begin
      cm_kind_d = CM_NONE;
      cm_idx_d  = '0;
      if (ev_on_q) begin
         if (hit_found_d) begin
            cm_kind_d = CM_ON;
            cm_idx_d  = hit_idx_d;
         end else if (free_found_d) begin
            cm_kind_d = CM_ON;
            cm_idx_d  = free_idx_d;
         end else if (rel_found_d) begin
            cm_kind_d = CM_ON;
            cm_idx_d  = rel_idx_d;
         end else begin
            // reaching here means every slot is held
`ifdef VOICE_ALLOC_STEAL_EN
            cm_kind_d = CM_STEAL;
            cm_idx_d  = old_idx_d;
`else
            cm_kind_d = CM_DROP;
`endif
         end
      end else if (hit_found_d) begin
         cm_kind_d = CM_OFF;
         cm_idx_d  = hit_idx_d;
      end else begin
         cm_kind_d = CM_OFF_ERR;
      end
   end

   // ---------------- event latch and scan trackers ----------------
   always_ff @(posedge CLOCK_25 or posedge iRST) begin
      if (iRST) begin
         idx_q        <= '0;
         ev_on_q      <= 1'b0;
         ev_key_q     <= '0;
         ev_vel_q     <= '0;
         hit_found_q  <= 1'b0;
         hit_idx_q    <= '0;
         free_found_q <= 1'b0;
         free_idx_q   <= '0;
         rel_found_q  <= 1'b0;
         rel_idx_q    <= '0;
         rel_age_q    <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
         old_found_q  <= 1'b0;
         old_idx_q    <= '0;
         old_age_q    <= '0;
`endif
      end else if (accept) begin
         idx_q        <= '0;
         ev_on_q      <= ev_on;
         ev_key_q     <= ev_key;
         ev_vel_q     <= ev_vel;
         hit_found_q  <= 1'b0;
         free_found_q <= 1'b0;
         rel_found_q  <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
         old_found_q  <= 1'b0;
`endif
      end else if (state_q == SCAN) begin
         idx_q        <= idx_q + V_WIDTH'(1);
         hit_found_q  <= hit_found_d;
         hit_idx_q    <= hit_idx_d;
         free_found_q <= free_found_d;
         free_idx_q   <= free_idx_d;
         rel_found_q  <= rel_found_d;
         rel_idx_q    <= rel_idx_d;
         rel_age_q    <= rel_age_d;
`ifdef VOICE_ALLOC_STEAL_EN
         old_found_q  <= old_found_d;
         old_idx_q    <= old_idx_d;
         old_age_q    <= old_age_d;
`endif
      end
   end

   // ---------------- commit: lands on the edge entering COMMIT ----------------
   always_ff @(posedge CLOCK_25 or posedge iRST) begin
      if (iRST) begin
         kind_q     <= CM_NONE;
         keys_on_q  <= '0;
         cur_adr_q  <= '0;
         cur_key_q  <= '0;
         cur_von_q  <= '0;
         cur_voff_q <= '0;
      end else if (scan_last) begin
         kind_q <= cm_kind_d;
         case (cm_kind_d)
            CM_ON, CM_STEAL: begin
               keys_on_q[cm_idx_d] <= 1'b1;
               cur_adr_q           <= cm_idx_d;
               cur_key_q           <= ev_key_q;
               cur_von_q           <= ev_vel_q;
            end
            CM_OFF: begin
               keys_on_q[cm_idx_d] <= 1'b0;
               cur_adr_q           <= cm_idx_d;
               cur_key_q           <= ev_key_q;
               cur_voff_q          <= ev_vel_q;
            end
            default: ;
         endcase
      end
   end

   assign tbl_wr = scan_last && ((cm_kind_d == CM_ON) || (cm_kind_d == CM_STEAL));

   voice_age_table #(
      .VOICES  (VOICES),
      .V_WIDTH (V_WIDTH),
      .AGE_W   (AGE_W)
   ) u_age_table (
      .clk_i      (CLOCK_25),
      .rst_i      (iRST),
      .wr_en_i    (tbl_wr),
      .wr_idx_i   (cm_idx_d),
      .wr_key_i   (ev_key_q),
      .held_i     (keys_on_q),
      .slot_key_o (slot_key),
      .slot_age_o (slot_age)
   );

   always_comb begin
      active_keys = '0;
      for (int i = 0; i < VOICES; i++) begin
         active_keys = active_keys + {{V_WIDTH{1'b0}}, keys_on_q[i]};
      end
   end

   assign keys_on     = keys_on_q;
   assign cur_key_adr = cur_adr_q;
   assign cur_key_val = {1'b0, cur_key_q};
   assign cur_vel_on  = {1'b0, cur_von_q};
   assign cur_vel_off = {1'b0, cur_voff_q};

endmodule
